// File: rtl/alu_input_sequencer_if.sv
// Bus between the ALU input sequencer and its surroundings: button, switches,
// ALU operands/result and status indicators.
`timescale 1ns/1ps
interface alu_input_sequencer_if #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned OP_SIZE   = 4
);
  logic                 key_ok;
  logic [WORD_SIZE-1:0] sw_in;
  logic [WORD_SIZE-1:0] alu_out;
  logic                 alu_zero_flag;
  logic [WORD_SIZE-1:0] data_1;
  logic [WORD_SIZE-1:0] data_2;
  logic [OP_SIZE-1:0]   sel;
  logic [WORD_SIZE-1:0] result;
  logic                 zero;
  logic                 valid;
  logic                 err;
  logic [3:0]           timer;

  // Environment side: button, switches and the ALU itself.
  modport master (
    output key_ok, sw_in, alu_out, alu_zero_flag,
    input  data_1, data_2, sel, result, zero, valid, err, timer
  );

  // Sequencer side.
  modport slave (
    input  key_ok, sw_in, alu_out, alu_zero_flag,
    output data_1, data_2, sel, result, zero, valid, err, timer
  );
endinterface

// File: rtl/alu_input_sequencer.sv
// ALU input sequencer: synchronizes and debounces the active-low key, then on
// successive presses loads operand A, operand B and the opcode, captures the
// ALU result one cycle later and shows progress on the timer LEDs.
// Optional opcode validation is enabled by defining SEQ_SEL_CHECK_EN.
`timescale 1ns/1ps
module alu_input_sequencer #(
  parameter int unsigned WORD_SIZE       = 16,
  parameter int unsigned OP_SIZE         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  rst,
  alu_input_sequencer_if.slave io_bus
);

  localparam logic [19:0] DbLast = 20'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {StA, StB, StOp, StExec, StShow} state_t;

  logic [1:0]           r_sync;
  logic                 w_key_sync;
  logic [19:0]          r_db_cnt;
  logic                 r_db_level;
  logic                 r_press;
  state_t               r_state;
  state_t               w_state_next;
  logic                 w_op_ok;
  logic [WORD_SIZE-1:0] r_data_1;
  logic [WORD_SIZE-1:0] r_data_2;
  logic [OP_SIZE-1:0]   r_sel;
  logic [WORD_SIZE-1:0] r_result;
  logic                 r_zero;
  logic                 r_valid;
  logic [3:0]           w_timer;

  assign w_key_sync = r_sync[1];

  // Two-flop synchronizer for the asynchronous key, idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], io_bus.key_ok};
    end
  end

  // Debouncer; also emits a registered one-cycle pulse on the 1->0 level change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt   <= 20'd0;
      r_db_level <= 1'b1;
      r_press    <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_key_sync != r_db_level) begin
        if (r_db_cnt == DbLast) begin
          r_db_cnt   <= 20'd0;
          r_db_level <= w_key_sync;
          r_press    <= r_db_level;
        end else begin
          r_db_cnt <= r_db_cnt + 20'd1;
        end
      end else begin
        r_db_cnt <= 20'd0;
      end
    end
  end

`ifdef SEQ_SEL_CHECK_EN
  assign w_op_ok = io_bus.sw_in[3:0] inside {4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001};
`else
  assign w_op_ok = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StA;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; a press during StExec is ignored.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StA:     if (r_press) w_state_next = StB;
      StB:     if (r_press) w_state_next = StOp;
      StOp:    if (r_press && w_op_ok) w_state_next = StExec;
      StExec:  w_state_next = StShow;
      StShow:  if (r_press) w_state_next = StA;
      default: w_state_next = StA;
    endcase
  end

  // FSM outputs: step indicator.
  always_comb begin
    w_timer = 4'b0001;
    unique case (r_state)
      StA:     w_timer = 4'b0001;
      StB:     w_timer = 4'b0010;
      StOp:    w_timer = 4'b0100;
      StExec:  w_timer = 4'b0000;
      StShow:  w_timer = 4'b1000;
      default: w_timer = 4'b0001;
    endcase
  end

  // Operand/opcode loads, result capture and the valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_1 <= '0;
      r_data_2 <= '0;
      r_sel    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= (r_state == StExec);
      if (r_state == StA && r_press) r_data_1 <= io_bus.sw_in;
      if (r_state == StB && r_press) r_data_2 <= io_bus.sw_in;
      if (r_state == StOp && r_press && w_op_ok) r_sel <= io_bus.sw_in[OP_SIZE-1:0];
      if (r_state == StExec) begin
        r_result <= io_bus.alu_out;
        r_zero   <= io_bus.alu_zero_flag;
      end
    end
  end

`ifdef SEQ_SEL_CHECK_EN
  logic r_err;

  // Sticky error: set by a rejected opcode press, cleared by an accepted one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == StOp && r_press) begin
      r_err <= ~w_op_ok;
    end
  end

  assign io_bus.err = r_err;
`else
  assign io_bus.err = 1'b0;
`endif

  assign io_bus.data_1 = r_data_1;
  assign io_bus.data_2 = r_data_2;
  assign io_bus.sel    = r_sel;
  assign io_bus.result = r_result;
  assign io_bus.zero   = r_zero;
  assign io_bus.valid  = r_valid;
  assign io_bus.timer  = w_timer;

endmodule
